// File: rtl/relu_seq.sv
// Job sequencer for an external combinational ReLU datapath: streams vec_num
// 512-bit vectors from the bias source through a single-entry output register.
module relu_seq #(
    parameter int DATA_W = 512,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_relu_en,
    input  logic [CNT_W-1:0]  i_vec_num,
    input  logic              i_bias_vld,
    output logic              o_bias_rdy,
    output logic              o_calc_en,
    input  logic [DATA_W-1:0] i_relu_dat,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_dat_vld,
    input  logic              i_dat_rdy,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t            state_q, state_d;
    logic              relu_en_q, relu_en_d;
    logic [CNT_W-1:0]  vec_num_q, vec_num_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              dat_vld_q, dat_vld_d;

    logic bias_rdy;
    logic in_xfer;
    logic out_xfer;
    logic in_last;
    logic out_last;

    // Ready passes through when the output slot is empty or draining this cycle.
    always_comb begin
        bias_rdy = (state_q == RUN) && (in_cnt_q < vec_num_q) && (!dat_vld_q || i_dat_rdy);
        in_xfer  = i_bias_vld && bias_rdy;
        out_xfer = dat_vld_q && i_dat_rdy;
        in_last  = in_xfer && ((in_cnt_q + ONE) == vec_num_q);
        out_last = out_xfer && ((out_cnt_q + ONE) == vec_num_q);
    end

    always_comb begin
        state_d   = state_q;
        relu_en_d = relu_en_q;
        vec_num_d = vec_num_q;
        in_cnt_d  = in_xfer ? (in_cnt_q + ONE) : in_cnt_q;
        out_cnt_d = out_xfer ? (out_cnt_q + ONE) : out_cnt_q;
        dat_d     = dat_q;
        dat_vld_d = dat_vld_q;

        if (in_xfer) begin
            dat_d     = i_relu_dat;
            dat_vld_d = 1'b1;
        end else if (out_xfer) begin
            dat_vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_vec_num != '0) begin
                        state_d   = RUN;
                        relu_en_d = i_relu_en;
                        vec_num_d = i_vec_num;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (in_last) begin
                    state_d = out_last ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (out_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            relu_en_q <= 1'b0;
            vec_num_q <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            dat_q     <= '0;
            dat_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            relu_en_q <= relu_en_d;
            vec_num_q <= vec_num_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            dat_q     <= dat_d;
            dat_vld_q <= dat_vld_d;
        end
    end

    assign o_bias_rdy = bias_rdy;
    assign o_calc_en  = (state_q == RUN) && relu_en_q;
    assign o_dat      = dat_q;
    assign o_dat_vld  = dat_vld_q;
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);

endmodule

// File: tb/tb_relu_seq.sv
// Scoreboard bench for relu_seq: per-job expected vectors are queued at issue,
// a negedge monitor pops and compares on every output handshake.
module tb_relu_seq;
    localparam int DW    = 512;
    localparam int LANES = 32;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic          i_relu_en;
    logic [15:0]   i_vec_num;
    logic          i_bias_vld;
    logic          o_bias_rdy;
    logic          o_calc_en;
    logic [DW-1:0] i_relu_dat;
    logic [DW-1:0] o_dat;
    logic          o_dat_vld;
    logic          i_dat_rdy;
    logic          o_busy;
    logic          o_done;
    logic [DW-1:0] bias;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] src[$];
    int out_count     = 0;
    int done_count    = 0;
    int first_out_cyc = 0;
    int last_out_cyc  = 0;

    relu_seq dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_relu_en  (i_relu_en),
        .i_vec_num  (i_vec_num),
        .i_bias_vld (i_bias_vld),
        .o_bias_rdy (o_bias_rdy),
        .o_calc_en  (o_calc_en),
        .i_relu_dat (i_relu_dat),
        .o_dat      (o_dat),
        .o_dat_vld  (o_dat_vld),
        .i_dat_rdy  (i_dat_rdy),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // Environment stand-in for the combinational ReLU datapath.
    function automatic logic [DW-1:0] datapath(input logic [DW-1:0] v, input logic en);
        logic signed [15:0] lane;
        datapath = v;
        if (en) begin
            for (int l = 0; l < LANES; l++) begin
                lane = v[l*16 +: 16];
                if (lane < 0) datapath[l*16 +: 16] = 16'h0000;
            end
        end
    endfunction

    assign i_relu_dat = datapath(bias, o_calc_en);

    // Reference: a job result lane is zero when relu is enabled and the lane is negative.
    function automatic logic [DW-1:0] expect_vec(input logic [DW-1:0] v, input bit ren);
        expect_vec = v;
        for (int l = 0; l < LANES; l++) begin
            if (ren && v[l*16+15]) expect_vec[l*16 +: 16] = 16'h0000;
        end
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on output handshake plus stall-behaviour checks.
    initial begin
        bit            stall_prev;
        logic [DW-1:0] held;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_hold_dat", o_dat, held);
                    chkb("stall_hold_vld", o_dat_vld, 1'b1);
                end
                if (o_dat_vld && !i_dat_rdy) chkb("stall_bias_rdy", o_bias_rdy, 1'b0);
                if (o_dat_vld && i_dat_rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output cycle %0d: got %h expected none", cyc, o_dat);
                    end else begin
                        chk("out_data", o_dat, exp_q.pop_front());
                    end
                    if (out_count == 0) first_out_cyc = cyc;
                    last_out_cyc = cyc;
                    out_count++;
                end
                if (o_done) done_count++;
                stall_prev = o_dat_vld && !i_dat_rdy;
                held       = o_dat;
            end
        end
    end

    // Runs one job; caller and return are both at posedge+1.
    task automatic run_job(input int n, input bit ren, input int vld_pct, input int rdy_mode,
                           input bit fixed_lane, input bit poke_start, input int abort_after);
        int            idx, budget, waited, calc_cycles, busy_cycles, rdy_cycles, first_in_cyc, done_cyc;
        bit            xfer, seen_done;
        logic [DW-1:0] v;
        idx = 0; waited = 0; calc_cycles = 0; busy_cycles = 0; rdy_cycles = 0;
        first_in_cyc = -1; done_cyc = -1; seen_done = 1'b0; v = '0;
        src.delete();
        exp_q.delete();
        out_count  = 0;
        done_count = 0;
        for (int k = 0; k < n; k++) begin
            for (int l = 0; l < LANES; l++) v[l*16 +: 16] = fixed_lane ? 16'h8001 : 16'($urandom);
            src.push_back(v);
            exp_q.push_back(expect_vec(v, ren));
        end
        budget = 20 * n + 50;

        i_start   = 1'b1;
        i_relu_en = ren;
        i_vec_num = 16'(n);
        @(posedge i_clk); #1;
        i_start   = 1'b0;
        i_relu_en = 1'($urandom);
        i_vec_num = 16'($urandom);

        while (!seen_done && waited < budget) begin
            i_bias_vld = (idx < n) && ($urandom_range(99) < vld_pct);
            bias       = (idx < n) ? src[idx] : {16{$urandom}};
            case (rdy_mode)
                0:       i_dat_rdy = 1'b1;
                1:       i_dat_rdy = waited[0];
                default: i_dat_rdy = 1'($urandom_range(1));
            endcase
            if (poke_start && waited == 3 && o_busy) begin
                i_start   = 1'b1;
                i_vec_num = 16'(n + 7);
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clk);
            xfer = i_bias_vld && o_bias_rdy;
            if (xfer && first_in_cyc < 0) first_in_cyc = cyc;
            if (o_calc_en) calc_cycles++;
            if (o_busy) busy_cycles++;
            if (o_bias_rdy) rdy_cycles++;
            if (o_done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
            end
            @(posedge i_clk); #1;
            if (xfer) idx++;
            waited++;
            if (abort_after > 0 && out_count >= abort_after) begin
                i_start = 1'b0;
                chkb("abort_pre_vld", o_dat_vld, 1'b1);
                i_rst_n = 1'b0;
                #1;
                chkb("abort_vld", o_dat_vld, 1'b0);
                chkb("abort_busy", o_busy, 1'b0);
                chkb("abort_bias_rdy", o_bias_rdy, 1'b0);
                chkb("abort_calc_en", o_calc_en, 1'b0);
                chk("abort_dat", o_dat, '0);
                exp_q.delete();
                repeat (2) begin
                    @(negedge i_clk);
                    chkb("abort_done_in_reset", o_done, 1'b0);
                end
                @(posedge i_clk); #1;
                i_rst_n    = 1'b1;
                i_bias_vld = 1'b0;
                repeat (3) begin
                    @(negedge i_clk);
                    chkb("post_abort_busy", o_busy, 1'b0);
                    chkb("post_abort_done", o_done, 1'b0);
                end
                @(posedge i_clk); #1;
                chki("abort_no_done", done_count, 0);
                return;
            end
        end
        i_bias_vld = 1'b0;
        i_start    = 1'b0;
        i_dat_rdy  = 1'b1;
        if (!seen_done) begin
            checks++;
            failures++;
            $display("FAIL job_timeout n=%0d: got no o_done expected o_done within %0d cycles", n, budget);
        end
        repeat (2) begin
            @(negedge i_clk);
            chkb("after_job_busy", o_busy, 1'b0);
            chkb("after_job_done", o_done, 1'b0);
        end
        @(posedge i_clk); #1;
        chki("out_count", out_count, n);
        chki("exp_left", exp_q.size(), 0);
        chki("done_count", done_count, 1);
        if (n > 0) chki("done_after_last_out", done_cyc - last_out_cyc, 1);
        if (!ren) chki("bypass_calc_cycles", calc_cycles, 0);
        if (n == 0) begin
            chki("zero_busy_cycles", busy_cycles, 1);
            chki("zero_bias_rdy_cycles", rdy_cycles, 0);
        end
        if (n > 0 && rdy_mode == 0 && vld_pct == 100) begin
            chki("latency", first_out_cyc - first_in_cyc, 1);
            chki("back_to_back", last_out_cyc - first_out_cyc, n - 1);
            if (ren) chki("calc_cycles", calc_cycles, n);
        end
    endtask

    initial begin
        i_rst_n    = 1'b1;
        i_start    = 1'b0;
        i_relu_en  = 1'b0;
        i_vec_num  = '0;
        i_bias_vld = 1'b1;
        i_dat_rdy  = 1'b1;
        bias       = '0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chkb("reset_dat_vld", o_dat_vld, 1'b0);
        chkb("reset_done", o_done, 1'b0);
        chkb("reset_bias_rdy", o_bias_rdy, 1'b0);
        chkb("reset_calc_en", o_calc_en, 1'b0);
        chkb("reset_busy", o_busy, 1'b0);
        chk("reset_dat", o_dat, '0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n    = 1'b1;
        i_bias_vld = 1'b0;
        @(negedge i_clk);
        chkb("idle_after_reset_busy", o_busy, 1'b0);
        @(posedge i_clk); #1;

        run_job(4, 1'b1, 100, 0, 1'b0, 1'b0, 0);
        run_job(3, 1'b1, 50, 1, 1'b0, 1'b0, 0);
        run_job(0, 1'b1, 100, 0, 1'b0, 1'b0, 0);
        run_job(3, 1'b0, 100, 0, 1'b1, 1'b0, 0);
        run_job(3, 1'b1, 100, 0, 1'b1, 1'b0, 0);
        run_job(6, 1'b1, 70, 2, 1'b0, 1'b1, 0);
        run_job(5, 1'b1, 100, 0, 1'b0, 1'b0, 2);
        run_job(2, 1'b1, 100, 0, 1'b0, 1'b0, 0);
        for (int j = 0; j < 4; j++) begin
            run_job(int'($urandom_range(20, 1)), 1'($urandom), int'($urandom_range(100, 30)), 2,
                    1'b0, 1'b0, 0);
        end
        run_job(65535, 1'b1, 100, 0, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/relu_seq.md
RELU_SEQ -- requirements
Module: relu_seq

Interface
REQ-001 i_clk  input  1  single clock; all state on rising edge.
REQ-002 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 i_start  input  1  one-cycle job start pulse; sampled only in IDLE.
REQ-004 i_relu_en  input  1  ReLU enable for the job; latched at accepted start.
REQ-005 i_vec_num  input  16  number of 512-bit vectors in the job; latched at accepted start.
REQ-006 i_bias_vld  input  1  upstream bias vector valid.
REQ-007 o_bias_rdy  output  1  upstream ready; a transfer occurs when i_bias_vld and o_bias_rdy are both high.
REQ-008 o_calc_en  output  1  drives the combinational relu datapath i_calc_en; equals latched relu_en while state is RUN, else 0.
REQ-009 i_relu_dat  input  512  relu datapath output (32 lanes x 16 bit), already valid in the cycle of the transfer.
REQ-010 o_dat  output  512  registered result vector.
REQ-011 o_dat_vld  output  1  o_dat valid.
REQ-012 i_dat_rdy  input  1  downstream ready; output transfer when o_dat_vld and i_dat_rdy are both high.
REQ-013 o_busy  output  1  high in every state except IDLE.
REQ-014 o_done  output  1  one-cycle pulse at job completion.

Function
REQ-015 States: IDLE, RUN, DRAIN, DONE. Encoding is free.
REQ-016 IDLE->RUN on i_start when i_vec_num!=0: latch relu_en and vec_num, and clear in_cnt and out_cnt (16 bit each).
REQ-017 IDLE->DONE on i_start when i_vec_num==0; no data moves.
REQ-018 i_start outside IDLE shall be ignored with no effect on the job.
REQ-019 o_bias_rdy = (state==RUN) and (in_cnt<vec_num) and (!o_dat_vld or i_dat_rdy); this is a single-entry output register with pass-through ready.
REQ-020 On an input transfer: o_dat <= i_relu_dat, o_dat_vld <= 1, in_cnt += 1.
REQ-021 On an output transfer with no simultaneous input transfer: o_dat_vld <= 0. With a simultaneous input transfer: o_dat_vld stays 1 and o_dat takes the new data.
REQ-022 Each output transfer increments out_cnt. Latency is 1 cycle from input transfer to o_dat_vld.
REQ-023 RUN->DRAIN on the input transfer that makes in_cnt==vec_num.
REQ-024 DRAIN->DONE on the output transfer that makes out_cnt==vec_num. If the last output transfer coincides with entering DRAIN (possible only when in and out complete in the same cycle), the FSM goes RUN->DONE directly.
REQ-025 DONE: o_done=1 for exactly one cycle, then the FSM goes to IDLE.
REQ-026 o_dat holds its value while o_dat_vld=1 and i_dat_rdy=0; no data is lost or duplicated under any vld/rdy pattern.
REQ-027 o_calc_en=0 in DRAIN, DONE and IDLE; the datapath then passes data unmodified, but nothing is captured in those states.
REQ-028 Counters never wrap: vec_num=16'hFFFF is a legal job of 65535 vectors.

Reset
REQ-029 While i_rst_n=0, asynchronously: state=IDLE; in_cnt, out_cnt, relu_en and vec_num = 0; o_dat=512'h0; o_dat_vld=0; o_done=0.
REQ-030 Outputs during reset: o_bias_rdy=0, o_calc_en=0, o_busy=0.
REQ-031 Reset asserted mid-job aborts the job: the pending o_dat is discarded and no o_done is issued. After release, the block waits in IDLE for a new i_start.

Verification
REQ-032 Basic job: start with vec_num=4, relu_en=1, i_bias_vld=1 throughout, i_dat_rdy=1 -> o_calc_en=1 for 4 cycles, 4 outputs back-to-back at 1-cycle latency, o_done one cycle after the last output, then o_busy=0.
REQ-033 Backpressure: vec_num=3, i_dat_rdy low on alternate cycles, random i_bias_vld -> exactly 3 outputs in order, o_dat stable while stalled, o_bias_rdy=0 whenever o_dat_vld=1 and i_dat_rdy=0.
REQ-034 Zero length: start with vec_num=0 -> o_busy=1 for 1 cycle, o_done pulses the cycle after start, and o_bias_rdy stays 0.
REQ-035 Bypass: relu_en=0 with lane value 16'h8001 -> o_calc_en=0 and o_dat lane = 16'h8001. The same job with relu_en=1 -> lane = 16'h0000.
REQ-036 Ignored start and abort: pulse i_start during RUN -> latched vec_num and counts are unchanged. Assert i_rst_n=0 after 2 of 5 vectors -> o_dat_vld drops asynchronously, no o_done, and a new job of 2 vectors completes normally afterwards.
REQ-037 Max length: vec_num=16'hFFFF, continuous flow -> exactly 65535 outputs and a single o_done.
